mem_access_hs: RTL
==================

Name: mem_access_hs

Overview:
- Parametrised successor to the fixed single-cycle memory access stage of the Beta pipeline.
- Holds one instruction in a stage register and issues at most one request on a req/gnt/rvalid memory port.
- Stalls upstream while a load or store is outstanding and returns load data to writeback.
- Adds valid/ready pipeline handshakes, configurable widths, a response timeout that converts hung loads into exceptions, and kill-by-ir_src.

Parameters:
- DW, 32, data width in bits; multiple of 8, at least 16.
- AW, 32, address width in bits.
- RSP_TIMEOUT, 255, maximum cycles waiting for rvalid after grant; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream stage has an instruction
- in_ready  out  1  stage can accept (combinational)
- ir_src  in  2  IR_SRC_EXCEPT / IR_SRC_NOP / IR_SRC_DATA (defines.v encodings)
- op_st  in  1  instruction is a store
- op_ld_or_ldr  in  1  instruction is LD/LDR
- rf_w_mux_jump  in  1  passthrough control
- pc, ir  in  32  passthrough
- y  in  AW  ALU result / effective byte address
- d  in  DW  store data
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback accepts
- pc_next, ir_next  out  32  registered results
- y_next  out  AW  registered
- ld_data_next  out  DW  registered load data
- op_ld_or_ldr_next, op_st_next, rf_w_mux_jump_next  out  1  registered
- bus_err  out  1  result was produced by a timeout
- misalign  out  1  result was produced by a misalignment trap
- mem_req  out  1  request valid
- mem_we  out  1  write request
- mem_addr  out  AW  byte address
- mem_wdata  out  DW  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  read data

Behaviour:
- States:
  - EMPTY: no instruction held.
  - REQ: mem_req=1, waiting for grant.
  - RSP: load granted, waiting for data.
  - DONE: result held, out_valid=1.
- Handshakes:
  - in_ready = (state==EMPTY) | (state==DONE & out_ready).
  - Capture happens when in_valid & in_ready.
  - A capture in DONE with out_ready gives back-to-back throughput of 1 instruction per cycle for non-memory ops.
- ir_next at capture:
  - IR_SRC_EXCEPT -> INST_BNE_EXCEPT.
  - IR_SRC_NOP -> INST_NOP.
  - IR_SRC_DATA -> ir.
  - Any other value -> INST_NOP.
- A memory op is (op_st | op_ld_or_ldr) & ir_src==IR_SRC_DATA.
  - Killed instructions never issue a request; their op_st_next and op_ld_or_ldr_next are registered as 0.
- Transitions after capture:
  - Memory op -> REQ.
  - Otherwise -> DONE. Latency 1 cycle: out_valid is high the cycle after capture.
- REQ:
  - mem_we=op_st, mem_addr=y with the low log2(DW/8) bits forced to 0, mem_wdata=d.
  - All request fields stay stable until mem_gnt.
  - On gnt: a store goes to DONE; a load goes to RSP and clears the timeout counter.
- RSP:
  - rvalid is legal at the earliest the cycle after gnt.
  - On rvalid: ld_data_next <= mem_rdata, go to DONE.
  - The counter increments each cycle without rvalid.
  - If RSP_TIMEOUT != 0 and the counter reaches RSP_TIMEOUT: go to DONE with ir_next=INST_BNE_EXCEPT, op_ld_or_ldr_next=0, bus_err=1, ld_data_next=0.
  - rvalid and timeout in the same cycle: data wins, no error.
- mem_rvalid outside RSP is ignored (stale response after a timeout or reset).
- Counter width is $clog2(RSP_TIMEOUT+1); it saturates and never wraps.
- DONE: outputs are held stable until out_ready.
- bus_err and misalign are cleared on every capture.
- Reset takes effect immediately from any state, including mid-request:
  - state=EMPTY.
  - mem_req=0, mem_we=0, out_valid=0, bus_err=0, misalign=0.
  - All data and control outputs = 0.
  - An in-flight grant is abandoned.

Optional Feature:
- MEM_ACCESS_MISALIGN_TRAP_EN
- Defined:
  - A memory op whose y low log2(DW/8) bits are nonzero issues no request.
  - It goes EMPTY -> DONE with ir_next=INST_BNE_EXCEPT, misalign=1, op_st_next=0, op_ld_or_ldr_next=0.
- Undefined:
  - Low bits are silently masked on mem_addr.
  - misalign is tied to 0.

Test Plan:
1. Store y=0x100, d=0xDEADBEEF, gnt 2 cycles after req -> mem_req high 3 cycles with we=1, addr=0x100, wdata=0xDEADBEEF; in_ready low throughout; out_valid the cycle after gnt; op_st_next=1.
2. Load y=0x204, gnt immediately, rvalid 3 cycles later with 0x12345678 -> ld_data_next=0x12345678, op_ld_or_ldr_next=1, bus_err=0; then out_ready held low 4 cycles -> outputs stable, in_ready low.
3. Stream of 5 ADDs with out_ready=1 -> one per cycle, no mem_req, ir_next equals the input ir 1 cycle later.
4. Load with ir_src=IR_SRC_EXCEPT -> no mem_req, ir_next=INST_BNE_EXCEPT, op_ld_or_ldr_next=0; with IR_SRC_NOP -> ir_next=INST_NOP.
5. RSP_TIMEOUT=4, load granted with no rvalid -> DONE after 4 RSP cycles, bus_err=1, ir_next=INST_BNE_EXCEPT; late rvalid next cycle ignored.
6. rst asserted while in REQ -> the next cycle mem_req=0, out_valid=0, in_ready=1. With MEM_ACCESS_MISALIGN_TRAP_EN defined, load at y=0x102 -> no request, misalign=1.

Source files
------------

// File: rtl/mem_access_hs.sv
// mem_access_hs: memory access pipeline stage with valid/ready handshakes.
// Holds one instruction and issues at most one request on a req/gnt/rvalid port.
// Hung loads are converted into exceptions by a response timeout.
// Optional build macro: MEM_ACCESS_MISALIGN_TRAP_EN. When it is defined, a
// misaligned memory op traps instead of issuing a request. When it is not
// defined, the low address bits are masked and misalign stays 0.
module mem_access_hs #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    ir_src,
  input  logic          op_st,
  input  logic          op_ld_or_ldr,
  input  logic          rf_w_mux_jump,
  input  logic [31:0]   pc,
  input  logic [31:0]   ir,
  input  logic [AW-1:0] y,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   pc_next,
  output logic [31:0]   ir_next,
  output logic [AW-1:0] y_next,
  output logic [DW-1:0] ld_data_next,
  output logic          op_ld_or_ldr_next,
  output logic          op_st_next,
  output logic          rf_w_mux_jump_next,
  output logic          bus_err,
  output logic          misalign,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  // Instruction-source encodings and the two substitute instructions.
  localparam logic [1:0]  IR_SRC_DATA     = 2'd0;
  localparam logic [1:0]  IR_SRC_EXCEPT   = 2'd1;
  localparam logic [1:0]  IR_SRC_NOP      = 2'd2;
  localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
  localparam logic [31:0] INST_BNE_EXCEPT = 32'h77DF_0000;

  // Byte-offset bits within one data word.
  localparam int LSB = $clog2(DW / 8);
  // The counter is kept at least 1 bit wide so that a disabled timeout still elaborates.
  localparam int CW  = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;
  // Counter value on the last RSP cycle before the timeout fires.
  localparam logic [CW-1:0] TMO_LAST = CW'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_EMPTY, S_REQ, S_RSP, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          capture;
  logic          data_src;
  logic          mem_op;
  logic          trap;
  logic [31:0]   ir_sel;
  logic [AW-1:0] addr_aligned;

  assign in_ready = (state == S_EMPTY) | ((state == S_DONE) & out_ready);
  assign capture  = in_valid & in_ready;
  assign data_src = (ir_src == IR_SRC_DATA);
  // Killed instructions (exception or nop source) never count as memory ops.
  assign mem_op   = (op_st | op_ld_or_ldr) & data_src;
  assign trap     = TRAP_EN & mem_op & (|y[LSB-1:0]);

  // Word-align the request address.
  always_comb begin
    addr_aligned          = y;
    addr_aligned[LSB-1:0] = '0;
  end

  // Select the instruction that moves on, based on its source.
  always_comb begin
    ir_sel = INST_NOP;
    case (ir_src)
      IR_SRC_DATA:   ir_sel = ir;
      IR_SRC_EXCEPT: ir_sel = INST_BNE_EXCEPT;
      IR_SRC_NOP:    ir_sel = INST_NOP;
      default:       ir_sel = INST_NOP;
    endcase
  end

  // Stage FSM: capture, memory request/response, timeout, and the result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_EMPTY;
      cnt                <= '0;
      out_valid          <= 1'b0;
      pc_next            <= '0;
      ir_next            <= '0;
      y_next             <= '0;
      ld_data_next       <= '0;
      op_ld_or_ldr_next  <= 1'b0;
      op_st_next         <= 1'b0;
      rf_w_mux_jump_next <= 1'b0;
      bus_err            <= 1'b0;
      misalign           <= 1'b0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
    end else if (capture) begin
      pc_next            <= pc;
      y_next             <= y;
      ld_data_next       <= '0;
      rf_w_mux_jump_next <= rf_w_mux_jump;
      bus_err            <= 1'b0;
      misalign           <= 1'b0;
      if (trap) begin
        // A misaligned access becomes an exception without touching memory.
        state             <= S_DONE;
        out_valid         <= 1'b1;
        ir_next           <= INST_BNE_EXCEPT;
        misalign          <= 1'b1;
        op_st_next        <= 1'b0;
        op_ld_or_ldr_next <= 1'b0;
      end else if (mem_op) begin
        state             <= S_REQ;
        out_valid         <= 1'b0;
        ir_next           <= ir_sel;
        op_st_next        <= op_st;
        op_ld_or_ldr_next <= op_ld_or_ldr;
        mem_req           <= 1'b1;
        mem_we            <= op_st;
        mem_addr          <= addr_aligned;
        mem_wdata         <= d;
      end else begin
        state             <= S_DONE;
        out_valid         <= 1'b1;
        ir_next           <= ir_sel;
        op_st_next        <= 1'b0;
        op_ld_or_ldr_next <= 1'b0;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (mem_we) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= S_RSP;
              cnt   <= '0;
            end
          end
        end
        S_RSP: begin
          if (mem_rvalid) begin
            // Data that arrives in the timeout cycle still wins.
            ld_data_next <= mem_rdata;
            state        <= S_DONE;
            out_valid    <= 1'b1;
          end else if ((RSP_TIMEOUT != 0) && (cnt >= TMO_LAST)) begin
            ld_data_next      <= '0;
            ir_next           <= INST_BNE_EXCEPT;
            op_ld_or_ldr_next <= 1'b0;
            bus_err           <= 1'b1;
            state             <= S_DONE;
            out_valid         <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
